// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: fetch FSM state encodings, datapath width and the
// default reset PC used by instr_fetch.
package cpu_defs;

  localparam int unsigned XLEN = 16;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_REQ   = 2'b00,
    ST_VALID = 2'b01,
    ST_HALT  = 2'b10
  } if_state_e;

endpackage

// File: rtl/instr_fetch_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] LP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + LP_ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: REQ/VALID/HALT FSM issuing one memory request per
// instruction. Optional performance counters are built when IF_PERF_CNT_EN is defined.
//
// Handshakes: imem_req stays high (address stable) until imem_ack is seen at a
// rising edge; instr_vld stays high (instr/pc stable) until an edge with stall=0.
module instr_fetch
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  instr,
  output logic [XLEN-1:0]  pc,
  output logic             instr_vld,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             hlt,
  output logic             halted,
`ifdef IF_PERF_CNT_EN
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] wait_cnt,
`endif
  output if_state_e        dbg_state
);

  if_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_vld;
  logic            r_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_REQ;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_vld    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_vld   <= 1'b1;
            r_state <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (!stall) begin
            r_vld <= 1'b0;
            // Halt wins over redirect and leaves PC on the halt instruction.
            if (hlt) begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end else begin
              r_pc    <= redirect ? redirect_pc : r_pc + 16'd1;
              r_state <= ST_REQ;
            end
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_REQ;
      endcase
    end
  end

  assign imem_req  = (r_state == ST_REQ) && !rst;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign instr_vld = r_vld;
  assign halted    = r_halted;
  assign dbg_state = r_state;

`ifdef IF_PERF_CNT_EN
  logic w_fetch_inc;
  logic w_wait_inc;

  assign w_fetch_inc = (r_state == ST_VALID) && !stall;
  assign w_wait_inc  = (r_state == ST_REQ) && !imem_ack;

  sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_fetch_inc),
    .o_cnt (fetch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_wait_inc),
    .o_cnt (wait_cnt)
  );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: driver plays memory and decode against a
// phase-level program model; a negedge monitor checks outputs and the fetch queue.
module tb_instr_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int          CW     = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        instr_vld;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        hlt = 1'b0;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [CW-1:0] fetch_cnt;
  logic [CW-1:0] wait_cnt;
`endif
  cpu_defs::if_state_e dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .instr_vld   (instr_vld),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hlt         (hlt),
    .halted      (halted),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt   (fetch_cnt),
    .wait_cnt    (wait_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // model: 0 fetching, 1 presenting to decode, 2 halted, 3 unknown (pre-reset)
  int          m_phase = 3;
  logic [15:0] m_pc = RST_PC;
  logic [CW-1:0] m_wait = '0;
  logic [CW-1:0] m_fetch = '0;
  bit          m_fresh = 1'b0;
  int          wait_left = 0;

  int          k_stall = 0, k_redir = 0, k_hlt = 0, k_wait = 0;
  bit          k_rpc_fix = 1'b0;
  logic [15:0] k_rpc = 16'h0000;

  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one clock of memory + decode stimulus, then advance the model
  task automatic cycle();
    int          n_phase = m_phase;
    logic [15:0] n_pc    = m_pc;
    logic [CW-1:0] n_wait  = m_wait;
    logic [CW-1:0] n_fetch = m_fetch;
    bit          n_fresh = m_fresh;
    stall       = ($urandom_range(99) < k_stall);
    redirect    = ($urandom_range(99) < k_redir);
    hlt         = ($urandom_range(99) < k_hlt);
    redirect_pc = k_rpc_fix ? k_rpc : 16'($urandom);
    imem_ack    = 1'($urandom_range(1));
    imem_rdata  = 16'($urandom);
    case (m_phase)
      0: begin
        if (wait_left == 0) begin
          imem_ack = 1'b1;
          exp_q.push_back({m_pc, imem_rdata});
          n_phase = 1;
          n_fresh = 1'b0;
        end else begin
          imem_ack = 1'b0;
          wait_left--;
          n_wait = n_wait + 1;
        end
      end
      1: begin
        if (!stall) begin
          n_fetch = n_fetch + 1;
          if (hlt) begin
            n_phase = 2;
          end else begin
            n_pc      = redirect ? redirect_pc : m_pc + 16'd1;
            n_phase   = 0;
            wait_left = ($urandom_range(2) == 0) ? $urandom_range(k_wait) : 0;
          end
        end
      end
      default: ;
    endcase
    @(posedge clk); #1;
    m_phase = n_phase;
    m_pc    = n_pc;
    m_wait  = n_wait;
    m_fetch = n_fetch;
    m_fresh = n_fresh;
  endtask

  // reset with a stale ack and random decode inputs present
  task automatic do_reset(input int cycles);
    rst         = 1'b1;
    imem_ack    = 1'b1;
    imem_rdata  = 16'($urandom);
    stall       = 1'($urandom_range(1));
    redirect    = 1'($urandom_range(1));
    hlt         = 1'($urandom_range(1));
    redirect_pc = 16'($urandom);
    repeat (cycles) begin
      @(posedge clk); #1;
      m_phase   = 0;
      m_pc      = RST_PC;
      m_wait    = '0;
      m_fetch   = '0;
      m_fresh   = 1'b1;
      wait_left = 0;
      exp_q.delete();
    end
    rst = 1'b0;
  endtask

  task automatic run_until(input string name, input int phase, input bit use_pc,
                           input logic [15:0] want_pc);
    int n = 0;
    while (!(m_phase == phase && (!use_pc || m_pc == want_pc)) && n < 300) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (n >= 300) begin
      n_err++;
      $display("FAIL %s: timeout, phase %0d pc %h expected phase %0d pc %h",
               name, m_phase, m_pc, phase, want_pc);
    end
  endtask

  // monitor / scoreboard
  logic        mon_prev_vld = 1'b0;
  logic [31:0] mon_cur = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_phase != 3) begin
        chk("imem_req", 32'(imem_req), 32'(m_phase == 0 && !rst));
        if (imem_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("instr_vld", 32'(instr_vld), 32'(m_phase == 1));
        chk("halted", 32'(halted), 32'(m_phase == 2));
        chk("pc", 32'(pc), 32'(m_pc));
        if (m_fresh) chk("instr_after_rst", 32'(instr), 32'h0);
        if (instr_vld && !mon_prev_vld) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL fetch_q: instr_vld with pc %h instr %h but nothing expected", pc, instr);
          end else begin
            mon_cur = exp_q.pop_front();
          end
        end
        if (instr_vld) chk("pc_instr", {pc, instr}, mon_cur);
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, m_fetch);
        chk("wait_cnt", wait_cnt, m_wait);
`endif
      end
      mon_prev_vld = instr_vld;
    end
  end

  initial begin
    do_reset(2);
    // zero-wait streaming
    repeat (12) cycle();
    // random traffic with stalls, redirects and wait states
    k_stall = 30; k_redir = 30; k_wait = 4;
    repeat (2000) cycle();
    // PC wrap at FFFF
    k_stall = 0; k_redir = 100; k_rpc_fix = 1'b1; k_rpc = 16'hFFFF; k_wait = 0;
    run_until("reach_ffff", 0, 1'b1, 16'hFFFF);
    k_redir = 0;
    repeat (8) cycle();
    // reset during REQ at 0033 with an ack in the reset cycle
    k_redir = 100; k_rpc = 16'h0033;
    run_until("reach_0033", 0, 1'b1, 16'h0033);
    k_redir = 0; k_rpc_fix = 1'b0;
    do_reset(1);
    repeat (10) cycle();
    // halt together with redirect, then reset out of HALT
    k_hlt = 100; k_redir = 100;
    run_until("reach_halt", 2, 1'b0, 16'h0000);
    k_hlt = 0; k_redir = 30;
    repeat (6) cycle();
    do_reset(2);
    repeat (10) cycle();
    // random with occasional halts and resets
    for (int r = 0; r < 10; r++) begin
      k_hlt = 2; k_stall = 25; k_redir = 25; k_wait = 3;
      repeat (300) cycle();
      do_reset(1 + $urandom_range(1));
    end
    k_hlt = 0;
    repeat (20) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage feeding the decoder. Holds the program counter and issues one request per instruction to instruction memory over a req/ack handshake. Presents the fetched word and its PC to decode. Advances to PC+1 or to the taken-branch target, and stops permanently on halt.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `CNT_W`, default 32: width of the performance counters (only with `IF_PERF_CNT_EN`).

- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset; synchronous and active-high.
- `imem_req`  out  1  — fetch request to instruction memory.
- `imem_addr`  out  16  — word address; stable while `imem_req`=1.
- `imem_ack`  in  1  — memory has data; sampled only while `imem_req`=1.
- `imem_rdata`  in  16  — instruction word; valid only when `imem_ack`=1.
- `instr`  out  16  — instruction to decode.
- `pc`  out  16  — PC of `instr`.
- `instr_vld`  out  1  — `instr`/`pc` are valid this cycle.
- `stall`  in  1  — downstream cannot retire the current instruction.
- `redirect`  in  1  — decode: taken branch or jump for the current instruction.
- `redirect_pc`  in  16  — next PC when `redirect`=1; ignored otherwise.
- `hlt`  in  1  — decode: the current instruction is a halt.
- `halted`  out  1  — the processor is halted.
- `fetch_cnt`  out  CNT_W  — instructions retired (only with `IF_PERF_CNT_EN`).
- `wait_cnt`  out  CNT_W  — REQ cycles without ack (only with `IF_PERF_CNT_EN`).

## Operation
- States: REQ, VALID, HALT.
- **Reset** (while `rst`=1, at the edge):
  - state is REQ; PC is `RESET_PC`.
  - `imem_req`=0, `instr_vld`=0, `halted`=0, `instr`=16'h0000, `pc`=`RESET_PC`, counters=0.
  - `imem_req` is gated low while `rst`=1.
- **REQ:**
  - `imem_req`=1 and `imem_addr`=PC.
  - On `imem_ack`=1: latch `imem_rdata` into `instr`, then go to VALID.
  - Otherwise stay in REQ with the address held.
- **VALID:**
  - `instr_vld`=1; `redirect`, `redirect_pc` and `hlt` are sampled at the edge.
  - `stall`=1: stay in VALID; all inputs ignored; outputs held.
  - `stall`=0 and `hlt`=1: go to HALT; PC holds the halt instruction address. `hlt` has priority over `redirect`.
  - `stall`=0, `hlt`=0, `redirect`=1: PC ← `redirect_pc`, go to REQ.
  - Otherwise: PC ← PC+1, modulo 2^16 (16'hFFFF wraps to 16'h0000), go to REQ.
- **HALT:**
  - `halted`=1, `instr_vld`=0, `imem_req`=0.
  - Exit only through `rst`.
- `imem_ack` is ignored outside REQ, including a stale ack after reset.
- `redirect`, `hlt` and `stall` are don't-care outside VALID.

## Timing
- Zero-wait memory (ack in the same cycle as the request): REQ one cycle, VALID one cycle. Throughput is one instruction per 2 cycles.
- N wait cycles add N cycles in REQ.
- `instr_vld` rises the cycle after the ack edge.
- The next `imem_addr` (PC+1 or `redirect_pc`) appears the cycle after VALID retires.
- `halted` rises the cycle after VALID with `hlt`=1, `stall`=0.
- Reset mid-REQ or mid-VALID: the in-flight fetch is abandoned. The first post-reset cycle is REQ at `RESET_PC`.
- All outputs are registered except `imem_req`, which is decoded from the state register and gated by `rst`.

## Configuration
- **`IF_PERF_CNT_EN` defined:**
  - Adds `fetch_cnt` and `wait_cnt`.
  - `fetch_cnt` increments on each VALID exit with `stall`=0; a halt counts.
  - `wait_cnt` increments each REQ cycle with `imem_ack`=0.
  - Both saturate at all-ones; both clear on `rst`.
- **Not defined:** the ports and the logic are absent. Behaviour is otherwise identical.

## Structure
- A shared package (`cpu_defs`) holds:
  - the state encodings (REQ=2'b00, VALID=2'b01, HALT=2'b10),
  - the 16-bit PC/instruction width constants,
  - the default `RESET_PC`.
- One sub-module, `sat_counter` (`CNT_W`-wide, inc/clear, saturating), is instantiated twice under `IF_PERF_CNT_EN`.

## Test plan
- **Reset then zero-wait fetch:** `rst` high 2 cycles, ack tied 1, rdata=16'h0123. Required: `imem_addr`=0000 first, `instr_vld` with `instr`=0123 and `pc`=0000 the next cycle, then address 0001.
- **Wait states:** ack delayed 3 cycles at PC 0005. Required: `imem_addr` holds 0005 for 4 cycles; `wait_cnt`=3; `instr_vld` only after the ack.
- **Redirect vs. halt:**
  - VALID at PC 0010 with `redirect`=1, `redirect_pc`=0040 → next `imem_addr`=0040.
  - `hlt`=1 together with `redirect`=1 → HALT; `halted`=1 the next cycle; no further `imem_req`.
- **Stall:** `stall`=1 for 4 cycles in VALID at PC 0020 with `redirect` toggling. Required: `instr`/`pc` held; after `stall` drops with `redirect`=0, next address is 0021.
- **Wrap:** PC FFFF, no redirect → next `imem_addr`=0000.
- **Reset mid-operation:**
  - `rst` during REQ at PC 0033 with ack arriving in the same cycle → post-reset `imem_addr`=`RESET_PC`; the stale data is not presented.
  - `rst` in HALT → `halted`=0 and fetch restarts.
